inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Instruction-fetch bus master in the IF stage, directly downstream of the PC register. Each cycle it reads the current PC and issues a read on the instruction bus. It registers the returned word with its PC into the IF/ID pipeline register and drives pc_enable back to the PC stage to advance or redirect it. It absorbs bus wait states and decode back-pressure through a one-entry hold buffer, and discards fetches on flush.

Parameters:
NOP_INSTR, 32'h00000000, bubble word driven on if_inst when if_valid=0 and after reset.

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  reset, asynchronous, active-low
pc  in  32  current PC from PC stage (registered there)
pc_enable  out  1  PC stage advance/redirect strobe (combinational)
flush  in  1  branch/exception/debug redirect; PC stage sees same-cycle redirect source
ibus_address  out  32  instruction bus address (combinational)
ibus_read  out  1  read request, held until accepted
ibus_rddata  in  32  read data, valid in cycle ibus_read=1 && ibus_stall=0
ibus_stall  in  1  bus wait state
id_ready  in  1  decode accepts if_* this cycle
if_valid  out  1  IF/ID register holds valid instruction
if_pc  out  32  PC of if_inst
if_inst  out  32  fetched instruction
if_exc_addr  out  1  fetch address error flag, qualified by if_valid

Behaviour:
- Reset (async, rst_n=0): state=IDLE; if_valid=0, if_pc=0, if_inst=NOP_INSTR, if_exc_addr=0, hold buffer empty; ibus_read=0, pc_enable=0.
- slot_free = !if_valid || id_ready. When id_ready=1 and nothing is loaded, if_valid<=0 and if_inst<=NOP_INSTR.
- IDLE: ibus_read=0. Moves to FETCH on the first clock after reset release.
- FETCH: ibus_read=1, ibus_address=pc.
  - ibus_stall=1: hold state, pc_enable=0. pc is stable, so the address stays stable.
  - ibus_stall=0 and slot_free: load {pc, ibus_rddata} into if_pc/if_inst, if_valid<=1, pc_enable=1, stay FETCH. Throughput is 1 instruction/cycle with zero-wait bus.
  - ibus_stall=0 and !slot_free: load hold buffer, pc_enable=1, go HOLD.
- HOLD: ibus_read=0, pc_enable=0. On id_ready: hold buffer moves to if_*, if_valid<=1, go FETCH.
- flush (highest priority, any state other than IDLE):
  - pc_enable=1 so the PC loads the redirect target.
  - Drop the output register: if_valid<=0, if_inst<=NOP_INSTR.
  - Drop the hold buffer.
  - Go FETCH, except for FETCH with ibus_stall=1: latch pc into drain_addr and go DRAIN.
- DRAIN: ibus_read=1, ibus_address=drain_addr until ibus_stall=0. Data is discarded, pc_enable=0, then go FETCH. A flush during DRAIN pulses pc_enable and stays DRAIN.
- A flush in the same cycle as a completing fetch discards that data. The fetch is never loaded.
- Bus protocol: ibus_read and ibus_address never change while ibus_stall=1 except by reset. No new request is issued in HOLD.
- Reset mid-transaction drops the request immediately; the bus must tolerate an aborted read on reset.
- if_pc/if_inst are unchanged when if_valid=1 and id_ready=0.

Optional Feature:
INST_FETCH_ADDR_CHECK_EN.
- Defined: in FETCH with pc[1:0]!=0, ibus_read=0, and the slot logic runs as for a completed fetch with if_inst=NOP_INSTR, if_exc_addr=1, pc_enable=0. The block then enters ERR (ibus_read=0, pc_enable=0) until flush. Flush behaves as in FETCH and returns to FETCH.
- Undefined: if_exc_addr is tied 0, ibus_address[1:0] is forced to 2'b00, and there is no ERR state.

Test Plan:
- Reset release, zero-wait bus, id_ready=1, pc starting 32'hbfc00000 -> ibus_read rises 1 cycle after release; pc_enable=1 every cycle; if_pc sequence bfc00000, bfc00004, ... with if_valid continuous.
- ibus_stall high 3 cycles on the first fetch -> ibus_address stays bfc00000, pc_enable=0 for 3 cycles, then one valid word with if_pc=bfc00000.
- id_ready=0 for 4 cycles while streaming -> one fetch goes to the hold buffer, then ibus_read=0. if_pc/if_inst stay frozen. On id_ready=1, no instruction is lost or duplicated.
- flush while ibus_stall=1 at 32'h80000100 -> pc_enable pulse, DRAIN keeps address 80000100 until stall drops, data discarded, next if_pc = redirect target.
- rst_n low mid-stall -> if_valid=0, ibus_read=0 asynchronously; restart from IDLE.
- With INST_FETCH_ADDR_CHECK_EN and pc=32'h80000002 -> no bus read, if_valid=1, if_exc_addr=1, if_inst=NOP_INSTR; held until flush.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch -- IF-stage instruction-fetch bus master.
//
// Reads the current PC each cycle and issues a read on the instruction bus.
// The returned word and its PC go into the IF/ID register (if_*). pc_enable
// tells the PC stage when to advance, or when to take a redirect during flush.
// A one-entry hold buffer absorbs a word that completes while decode is
// stalled. A fetch that is still outstanding when a flush arrives is drained
// and its data discarded.
//
// Optional feature macro: INST_FETCH_ADDR_CHECK_EN
//   Defined   : a misaligned PC (pc[1:0] != 0) is not sent to the bus. Instead
//               a NOP tagged with if_exc_addr=1 is delivered, and the block
//               parks in ERR until a flush.
//   Undefined : if_exc_addr is always 0 and ibus_address[1:0] is forced to 0.
//
// Ports:
//   clk           in   system clock, all state on posedge
//   rst_n         in   asynchronous active-low reset
//   pc[31:0]      in   current PC from the PC stage
//   pc_enable     out  PC advance/redirect strobe (combinational)
//   flush         in   redirect request (branch/exception/debug)
//   ibus_address  out  instruction bus address (combinational)
//   ibus_read     out  read request, held until accepted
//   ibus_rddata   in   read data, valid when ibus_read && !ibus_stall
//   ibus_stall    in   bus wait state
//   id_ready      in   decode accepts if_* this cycle
//   if_valid      out  IF/ID register holds a valid instruction
//   if_pc[31:0]   out  PC of if_inst
//   if_inst[31:0] out  fetched instruction (NOP_INSTR when empty)
//   if_exc_addr   out  fetch address error, qualified by if_valid
module inst_fetch #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic        pc_enable,
  input  logic        flush,
  output logic [31:0] ibus_address,
  output logic        ibus_read,
  input  logic [31:0] ibus_rddata,
  input  logic        ibus_stall,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_exc_addr
);

`ifdef INST_FETCH_ADDR_CHECK_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_HOLD, S_DRAIN, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_HOLD, S_DRAIN} state_t;
`endif

  state_t      state;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;
  logic [31:0] drain_addr;

  logic        slot_free;
  logic        addr_err;
  logic        fetch_done;
  logic        flush_act;
  logic [31:0] addr_sel;

  // The output register can take a new word if it is empty, or if its
  // current word is consumed this cycle.
  assign slot_free = !if_valid || id_ready;

`ifdef INST_FETCH_ADDR_CHECK_EN
  assign addr_err = (state == S_FETCH) && (pc[1:0] != 2'b00);
`else
  assign addr_err = 1'b0;
`endif

  assign fetch_done = (state == S_FETCH) && !addr_err && !ibus_stall;
  // A flush in IDLE is ignored because no request has been issued yet.
  assign flush_act  = flush && (state != S_IDLE);

  always_comb begin
    ibus_read = ((state == S_FETCH) && !addr_err) || (state == S_DRAIN);
    addr_sel  = (state == S_DRAIN) ? drain_addr : pc;
`ifdef INST_FETCH_ADDR_CHECK_EN
    ibus_address = addr_sel;
`else
    ibus_address = addr_sel & 32'hFFFF_FFFC;
`endif
    // A completed fetch always advances the PC. If the slot is busy, the
    // word is parked in the hold buffer instead of being refetched.
    pc_enable = flush_act || fetch_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      if_valid    <= 1'b0;
      if_pc       <= 32'h0;
      if_inst     <= NOP_INSTR;
      if_exc_addr <= 1'b0;
      hold_pc     <= 32'h0;
      hold_inst   <= 32'h0;
      drain_addr  <= 32'h0;
    end else begin
      // Default: decode consumed the current word and nothing replaces it.
      // The branches below override this when a word is loaded.
      if (id_ready) begin
        if_valid    <= 1'b0;
        if_inst     <= NOP_INSTR;
        if_exc_addr <= 1'b0;
      end

      if (flush_act) begin
        if_valid    <= 1'b0;
        if_inst     <= NOP_INSTR;
        if_exc_addr <= 1'b0;
      end

      case (state)
        S_IDLE: state <= S_FETCH;

        S_FETCH: begin
          if (flush) begin
            // An outstanding read cannot be withdrawn, so keep presenting it
            // and discard the data when it completes.
            if (ibus_stall) begin
              drain_addr <= pc;
              state      <= S_DRAIN;
            end else begin
              state <= S_FETCH;
            end
          end else if (addr_err) begin
            // The error word waits in FETCH (pc_enable=0) until the slot is free.
            if (slot_free) begin
              if_valid    <= 1'b1;
              if_pc       <= pc;
              if_inst     <= NOP_INSTR;
              if_exc_addr <= 1'b1;
`ifdef INST_FETCH_ADDR_CHECK_EN
              state       <= S_ERR;
`endif
            end
          end else if (!ibus_stall) begin
            if (slot_free) begin
              if_valid    <= 1'b1;
              if_pc       <= pc;
              if_inst     <= ibus_rddata;
              if_exc_addr <= 1'b0;
            end else begin
              hold_pc   <= pc;
              hold_inst <= ibus_rddata;
              state     <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (flush) begin
            state <= S_FETCH;
          end else if (id_ready) begin
            if_valid    <= 1'b1;
            if_pc       <= hold_pc;
            if_inst     <= hold_inst;
            if_exc_addr <= 1'b0;
            state       <= S_FETCH;
          end
        end

        S_DRAIN: begin
          // A flush here only redirects the PC. The drained read still has to
          // finish, so DRAIN is left only when the bus accepts it.
          if (!ibus_stall) state <= S_FETCH;
        end

`ifdef INST_FETCH_ADDR_CHECK_EN
        S_ERR: begin
          if (flush) state <= S_FETCH;
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch -- directed testbench for inst_fetch.
// Contains a minimal PC stage (advance by 4, or load the redirect target
// on flush) and a bus model whose read data is the address XOR A5A50000.
// Expected values are hand-computed constants.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_enable;
  logic        flush;
  logic [31:0] flush_target;
  logic [31:0] ibus_address;
  logic        ibus_read;
  logic [31:0] ibus_rddata;
  logic        ibus_stall;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_exc_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc           (pc),
    .pc_enable    (pc_enable),
    .flush        (flush),
    .ibus_address (ibus_address),
    .ibus_read    (ibus_read),
    .ibus_rddata  (ibus_rddata),
    .ibus_stall   (ibus_stall),
    .id_ready     (id_ready),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_exc_addr  (if_exc_addr)
  );

  // PC stage model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         pc <= 32'hbfc0_0000;
    else if (pc_enable) pc <= flush ? flush_target : pc + 32'd4;
  end

  // Bus model: the data pattern identifies the address that was read
  assign ibus_rddata = ibus_address ^ 32'hA5A5_0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] stream_pc   [4] = '{32'hbfc00000, 32'hbfc00004, 32'hbfc00008, 32'hbfc0000c};
  logic [31:0] stream_inst [4] = '{32'h1a650000, 32'h1a650004, 32'h1a650008, 32'h1a65000c};

  initial begin
    rst_n = 1'b0; flush = 1'b0; flush_target = 32'h0;
    ibus_stall = 1'b0; id_ready = 1'b1;
    tick(); tick();
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_pc",    if_pc, 32'h0);
    check("rst_inst",  if_inst, 32'h0);
    check("rst_exc",   {31'd0, if_exc_addr}, 32'd0);
    check("rst_read",  {31'd0, ibus_read}, 32'd0);
    check("rst_pcen",  {31'd0, pc_enable}, 32'd0);

    // Zero-wait streaming
    rst_n = 1'b1; #1;
    check("idle_read", {31'd0, ibus_read}, 32'd0);
    tick();
    check("first_read", {31'd0, ibus_read}, 32'd1);
    check("first_addr", ibus_address, 32'hbfc00000);
    check("first_pcen", {31'd0, pc_enable}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stream_valid", {31'd0, if_valid}, 32'd1);
      check("stream_pc",    if_pc, stream_pc[i]);
      check("stream_inst",  if_inst, stream_inst[i]);
      check("stream_pcen",  {31'd0, pc_enable}, 32'd1);
    end

    // Decode back-pressure for 4 cycles: bfc00010 goes to the hold buffer
    id_ready = 1'b0; #1;
    check("bp_pcen_in", {31'd0, pc_enable}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_read",  {31'd0, ibus_read}, 32'd0);
      check("bp_pcen",  {31'd0, pc_enable}, 32'd0);
      check("bp_valid", {31'd0, if_valid}, 32'd1);
      check("bp_pc",    if_pc, 32'hbfc0000c);
      check("bp_inst",  if_inst, 32'h1a65000c);
    end
    id_ready = 1'b1;
    tick();
    check("rel_pc",   if_pc, 32'hbfc00010);
    check("rel_inst", if_inst, 32'h1a650010);
    check("rel_read", {31'd0, ibus_read}, 32'd1);
    check("rel_addr", ibus_address, 32'hbfc00014);
    tick();
    check("rel_pc2",   if_pc, 32'hbfc00014);
    check("rel_inst2", if_inst, 32'h1a650014);

    // Flush coinciding with a completed fetch: that data is discarded
    flush = 1'b1; flush_target = 32'h80000100; #1;
    check("fl_pcen", {31'd0, pc_enable}, 32'd1);
    tick();
    flush = 1'b0; ibus_stall = 1'b1; #1;
    check("fl_valid", {31'd0, if_valid}, 32'd0);
    check("fl_inst",  if_inst, 32'h0);
    check("fl_addr",  ibus_address, 32'h80000100);
    check("fl_pcen0", {31'd0, pc_enable}, 32'd0);
    tick();
    check("st_addr", ibus_address, 32'h80000100);

    // Flush while stalled: the old address is drained
    flush = 1'b1; flush_target = 32'h80001000; #1;
    check("fs_pcen", {31'd0, pc_enable}, 32'd1);
    check("fs_addr", ibus_address, 32'h80000100);
    tick();
    flush = 1'b0; #1;
    check("dr_addr", ibus_address, 32'h80000100);
    check("dr_read", {31'd0, ibus_read}, 32'd1);
    check("dr_pcen", {31'd0, pc_enable}, 32'd0);
    tick();
    check("dr_addr2", ibus_address, 32'h80000100);
    ibus_stall = 1'b0; #1;
    check("dr_pcen_end", {31'd0, pc_enable}, 32'd0);
    tick();
    check("dr_valid", {31'd0, if_valid}, 32'd0);
    check("dr_next_addr", ibus_address, 32'h80001000);
    tick();
    check("tgt_valid", {31'd0, if_valid}, 32'd1);
    check("tgt_pc",    if_pc, 32'h80001000);
    check("tgt_inst",  if_inst, 32'h25a51000);

    // Asynchronous reset in the middle of a stall
    ibus_stall = 1'b1; #1;
    rst_n = 1'b0; #1;
    check("ar_valid", {31'd0, if_valid}, 32'd0);
    check("ar_read",  {31'd0, ibus_read}, 32'd0);
    check("ar_pcen",  {31'd0, pc_enable}, 32'd0);
    check("ar_inst",  if_inst, 32'h0);
    tick(); tick();
    rst_n = 1'b1; #1;
    check("rr_read_idle", {31'd0, ibus_read}, 32'd0);

    // First fetch after restart stalls for 3 cycles
    tick();
    check("s2_read", {31'd0, ibus_read}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      check("s2_addr",  ibus_address, 32'hbfc00000);
      check("s2_pcen",  {31'd0, pc_enable}, 32'd0);
      check("s2_valid", {31'd0, if_valid}, 32'd0);
    end
    ibus_stall = 1'b0; #1;
    check("s2_pcen_go", {31'd0, pc_enable}, 32'd1);
    tick();
    check("s2_valid1", {31'd0, if_valid}, 32'd1);
    check("s2_pc",     if_pc, 32'hbfc00000);
    check("s2_inst",   if_inst, 32'h1a650000);

    // Misaligned PC
    flush = 1'b1; flush_target = 32'h80000002;
    tick();
    flush = 1'b0; #1;
`ifdef INST_FETCH_ADDR_CHECK_EN
    check("ae_read", {31'd0, ibus_read}, 32'd0);
    check("ae_pcen", {31'd0, pc_enable}, 32'd0);
    tick();
    check("ae_valid", {31'd0, if_valid}, 32'd1);
    check("ae_exc",   {31'd0, if_exc_addr}, 32'd1);
    check("ae_inst",  if_inst, 32'h0);
    check("ae_pc",    if_pc, 32'h80000002);
    check("ae_read2", {31'd0, ibus_read}, 32'd0);
    id_ready = 1'b0;
    tick(); tick();
    check("ae_hold_valid", {31'd0, if_valid}, 32'd1);
    check("ae_hold_exc",   {31'd0, if_exc_addr}, 32'd1);
    check("ae_hold_pcen",  {31'd0, pc_enable}, 32'd0);
    check("ae_hold_read",  {31'd0, ibus_read}, 32'd0);
    flush = 1'b1; flush_target = 32'h80000010; #1;
    check("ae_fl_pcen", {31'd0, pc_enable}, 32'd1);
    tick();
    flush = 1'b0; id_ready = 1'b1; #1;
    check("ae_clr_valid", {31'd0, if_valid}, 32'd0);
    check("ae_clr_exc",   {31'd0, if_exc_addr}, 32'd0);
    check("ae_clr_read",  {31'd0, ibus_read}, 32'd1);
    check("ae_clr_addr",  ibus_address, 32'h80000010);
`else
    check("na_addr", ibus_address, 32'h80000000);
    check("na_read", {31'd0, ibus_read}, 32'd1);
    check("na_pcen", {31'd0, pc_enable}, 32'd1);
    tick();
    check("na_pc",   if_pc, 32'h80000002);
    check("na_inst", if_inst, 32'h25a50000);
    check("na_exc",  {31'd0, if_exc_addr}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
